// File: rtl/hazard_stall_unit.sv
//------------------------------------------------------------------------------
// Module      : hazard_stall_unit
// Description : Pipeline stall/flush controller covering load-use, branch-in-ID
//               operand dependencies and data-memory wait states.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_stall_unit #(
    parameter int LOAD_STALL  = 1,
    parameter int BR_LD_EXTRA = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RsAddr_i,
    input  logic [4:0]       IF_ID_RtAddr_i,
    input  logic             IF_ID_Branch_i,
    input  logic             Branch_Taken_i,
    input  logic             ID_EX_MemRead_i,
    input  logic             ID_EX_RegWrite_i,
    input  logic [4:0]       ID_EX_RdAddr_i,
    input  logic             Mem_Stall_i,
    output logic             PC_Write_o,
    output logic             IF_ID_Write_o,
    output logic             ID_EX_Bubble_o,
    output logic             IF_ID_Flush_o,
    output logic             Pipe_Freeze_o,
    output logic [CNT_W-1:0] Stall_Cnt_o
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_STALL  = 2'd1,
        S_FREEZE = 2'd2
    } stateT;

    // Remaining cycles after the detection cycle, for each multi-cycle hazard.
    localparam int         c_BrLdLen = LOAD_STALL + BR_LD_EXTRA;
    localparam logic [1:0] c_BrLdRem = 2'(c_BrLdLen - 1);
    localparam logic [1:0] c_LuRem   = 2'(LOAD_STALL - 1);

    stateT      r_state;
    stateT      w_stateNext;
    stateT      w_effState;
    logic [1:0] r_rem;
    logic [1:0] w_remNext;
    logic       r_ret;
    logic       w_retNext;

    logic w_match;
    logic w_brLd;
    logic w_lu;
    logic w_brAlu;
    logic w_hazard;
    logic w_multi;
    logic [1:0] w_hazRem;

    assign w_match = (ID_EX_RdAddr_i != 5'd0) &&
                     ((ID_EX_RdAddr_i == IF_ID_RsAddr_i) || (ID_EX_RdAddr_i == IF_ID_RtAddr_i));
    assign w_brLd   = IF_ID_Branch_i && ID_EX_MemRead_i && w_match;
    assign w_lu     = ID_EX_MemRead_i && w_match;
    assign w_brAlu  = IF_ID_Branch_i && ID_EX_RegWrite_i && !ID_EX_MemRead_i && w_match;
    assign w_hazard = w_brLd || w_lu || w_brAlu;

    always_comb begin
        w_multi  = 1'b0;
        w_hazRem = 2'd0;
        if (w_brLd) begin
            w_multi  = (c_BrLdLen > 1);
            w_hazRem = c_BrLdRem;
        end else if (w_lu) begin
            w_multi  = (LOAD_STALL > 1);
            w_hazRem = c_LuRem;
        end
    end

    // Leaving FREEZE behaves as the resumed state within the same cycle.
    assign w_effState = (r_state == S_FREEZE && !Mem_Stall_i) ? (r_ret ? S_STALL : S_RUN)
                                                              : r_state;

    always_comb begin
        w_stateNext    = w_effState;
        w_remNext      = r_rem;
        w_retNext      = r_ret;
        PC_Write_o     = 1'b1;
        IF_ID_Write_o  = 1'b1;
        ID_EX_Bubble_o = 1'b0;
        IF_ID_Flush_o  = 1'b0;
        Pipe_Freeze_o  = 1'b0;

        case (w_effState)
            S_RUN: begin
                w_retNext = 1'b0;
                if (Mem_Stall_i) begin
                    PC_Write_o    = 1'b0;
                    IF_ID_Write_o = 1'b0;
                    Pipe_Freeze_o = 1'b1;
                    w_stateNext   = S_FREEZE;
                end else if (w_hazard) begin
                    PC_Write_o     = 1'b0;
                    IF_ID_Write_o  = 1'b0;
                    ID_EX_Bubble_o = 1'b1;
                    if (w_multi) begin
                        w_stateNext = S_STALL;
                        w_remNext   = w_hazRem;
                    end
                end else if (Branch_Taken_i && IF_ID_Branch_i) begin
                    IF_ID_Flush_o = 1'b1;
                end
            end
            S_STALL: begin
                PC_Write_o    = 1'b0;
                IF_ID_Write_o = 1'b0;
                if (Mem_Stall_i) begin
                    Pipe_Freeze_o = 1'b1;
                    w_stateNext   = S_FREEZE;
                    w_retNext     = 1'b1;
                end else begin
                    ID_EX_Bubble_o = 1'b1;
                    w_remNext      = r_rem - 2'd1;
                    if (r_rem == 2'd1) begin
                        w_stateNext = S_RUN;
                        w_retNext   = 1'b0;
                    end
                end
            end
            default: begin
                PC_Write_o    = 1'b0;
                IF_ID_Write_o = 1'b0;
                Pipe_Freeze_o = 1'b1;
            end
        endcase

        // Reset holds the front end and feeds bubbles downstream.
        if (rst_i) begin
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
            IF_ID_Flush_o  = 1'b0;
            Pipe_Freeze_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
            r_rem   <= 2'd0;
            r_ret   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_rem   <= w_remNext;
            r_ret   <= w_retNext;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            Stall_Cnt_o <= '0;
        end else if (!PC_Write_o) begin
            Stall_Cnt_o <= Stall_Cnt_o + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_hazard_stall_unit
// Description : Directed vector and sequence bench for hazard_stall_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic        br = 1'b0, tk = 1'b0, mr = 1'b0, rw = 1'b0, ms = 1'b0;

    logic        pcW, ifW, bub, fl, frz;
    logic [31:0] cnt;
    logic        pcW4, ifW4, bub4, fl4, frz4;
    logic [3:0]  cnt4;

    int checks = 0;
    int failures = 0;

    // Output vector order: {PC_Write, IF_ID_Write, Bubble, Flush, Freeze}
    localparam logic [4:0] NORMAL = 5'b11000;
    localparam logic [4:0] STALL  = 5'b00100;
    localparam logic [4:0] FREEZE = 5'b00001;
    localparam logic [4:0] FLUSH  = 5'b11010;

    wire [4:0] outs = {pcW, ifW, bub, fl, frz};

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RsAddr_i(rs), .IF_ID_RtAddr_i(rt),
        .IF_ID_Branch_i(br), .Branch_Taken_i(tk),
        .ID_EX_MemRead_i(mr), .ID_EX_RegWrite_i(rw), .ID_EX_RdAddr_i(rd),
        .Mem_Stall_i(ms),
        .PC_Write_o(pcW), .IF_ID_Write_o(ifW), .ID_EX_Bubble_o(bub),
        .IF_ID_Flush_o(fl), .Pipe_Freeze_o(frz), .Stall_Cnt_o(cnt)
    );

    hazard_stall_unit #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RsAddr_i(rs), .IF_ID_RtAddr_i(rt),
        .IF_ID_Branch_i(br), .Branch_Taken_i(tk),
        .ID_EX_MemRead_i(mr), .ID_EX_RegWrite_i(rw), .ID_EX_RdAddr_i(rd),
        .Mem_Stall_i(ms),
        .PC_Write_o(pcW4), .IF_ID_Write_o(ifW4), .ID_EX_Bubble_o(bub4),
        .IF_ID_Flush_o(fl4), .Pipe_Freeze_o(frz4), .Stall_Cnt_o(cnt4)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic       br, tk, mr, rw;
        logic [4:0] rd;
        logic       ms;
        logic [4:0] exp;
    } vecT;

    vecT vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after the falling edge, leave time for the combinational settle.
    task automatic drive(input logic [4:0] iRs, input logic [4:0] iRt, input logic iBr,
                         input logic iTk, input logic iMr, input logic iRw,
                         input logic [4:0] iRd, input logic iMs);
        @(negedge clk);
        rs = iRs; rt = iRt; br = iBr; tk = iTk; mr = iMr; rw = iRw; rd = iRd; ms = iMs;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        rs = '0; rt = '0; rd = '0; br = 0; tk = 0; mr = 0; rw = 0; ms = 0;
        #1;
        chk("reset_outs", {27'd0, outs}, {27'd0, STALL});
        chk("reset_cnt", cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int expCnt;

    initial begin
        vecs[0]  = '{5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, STALL};  // load-use rs
        vecs[1]  = '{5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, NORMAL}; // ALU dep, forwarded
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, NORMAL}; // lw $0
        vecs[3]  = '{5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, STALL};  // load-use rt
        vecs[4]  = '{5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, STALL};  // branch-on-ALU, flush masked
        vecs[5]  = '{5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0, NORMAL}; // no RegWrite
        vecs[6]  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, FLUSH};  // taken branch
        vecs[7]  = '{5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, NORMAL}; // taken w/o branch
        vecs[8]  = '{5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b1, FREEZE}; // mem wait over hazard
        vecs[9]  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, FREEZE}; // mem wait over flush
        vecs[10] = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, FLUSH};  // resume to RUN
        vecs[11] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, NORMAL}; // rd=0 branch

        #1;
        chk("reset_t0_outs", {27'd0, outs}, {27'd0, STALL});
        doReset();

        // Table: single-cycle patterns starting from RUN
        expCnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].br, vecs[i].tk, vecs[i].mr, vecs[i].rw,
                  vecs[i].rd, vecs[i].ms);
            chk($sformatf("vec%0d", i), {27'd0, outs}, {27'd0, vecs[i].exp});
            if (vecs[i].exp[4] == 1'b0) expCnt++;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("table_cnt", cnt, 32'(expCnt));

        // Load-use: one stall then normal
        doReset();
        drive(5'd2, 5'd0, 0, 0, 1, 1, 5'd2, 0);
        chk("lu_stall", {27'd0, outs}, {27'd0, STALL});
        drive(5'd2, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        chk("lu_after", {27'd0, outs}, {27'd0, NORMAL});
        chk("lu_cnt", cnt, 32'd1);

        // Branch-on-load: two stalls, then flush
        doReset();
        drive(5'd1, 5'd3, 1, 1, 1, 1, 5'd3, 0);
        chk("brld_s1", {27'd0, outs}, {27'd0, STALL});
        drive(5'd1, 5'd3, 1, 1, 0, 0, 5'd0, 0);
        chk("brld_s2", {27'd0, outs}, {27'd0, STALL});
        drive(5'd1, 5'd3, 1, 1, 0, 0, 5'd0, 0);
        chk("brld_flush", {27'd0, outs}, {27'd0, FLUSH});
        chk("brld_cnt", cnt, 32'd2);

        // Branch-on-load with 3 cycles of memory wait inside the stall
        doReset();
        drive(5'd1, 5'd3, 1, 1, 1, 1, 5'd3, 0);
        chk("mw_s1", {27'd0, outs}, {27'd0, STALL});
        for (int i = 0; i < 3; i++) begin
            drive(5'd1, 5'd3, 1, 1, 0, 0, 5'd0, 1);
            chk($sformatf("mw_freeze%0d", i), {27'd0, outs}, {27'd0, FREEZE});
        end
        drive(5'd1, 5'd3, 1, 1, 0, 0, 5'd0, 0);
        chk("mw_s2", {27'd0, outs}, {27'd0, STALL});
        drive(5'd1, 5'd3, 1, 1, 0, 0, 5'd0, 0);
        chk("mw_flush", {27'd0, outs}, {27'd0, FLUSH});
        chk("mw_cnt", cnt, 32'd5);

        // Asynchronous reset in the middle of a stall
        doReset();
        drive(5'd1, 5'd3, 1, 0, 1, 1, 5'd3, 0);
        @(negedge clk);
        br = 0; mr = 0; rw = 0; rd = 0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_outs", {27'd0, outs}, {27'd0, STALL});
        chk("midrst_cnt", cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0);
        chk("midrst_run", {27'd0, outs}, {27'd0, NORMAL});
        chk("midrst_cnt_after", cnt, 32'd0);

        // 17 consecutive load-use stalls: 4-bit counter wraps to 1
        doReset();
        for (int i = 0; i < 17; i++) begin
            drive(5'd2, 5'd0, 0, 0, 1, 1, 5'd2, 0);
        end
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        chk("wrap_cnt4", {28'd0, cnt4}, 32'd1);
        chk("wrap_cnt32", cnt, 32'd17);
        chk("wrap_outs4", {27'd0, pcW4, ifW4, bub4, fl4, frz4}, {27'd0, NORMAL});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, limit 200000 reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
